uart_tx_queue: RTL and testbench
================================

Name: uart_tx_queue

Overview:
- Byte FIFO plus send sequencer that sits directly upstream of the uart transmitter.
- Accepts bytes from application logic (note/event reporting) at any rate up to one byte per clk.
- Drives the transmitter's send/send_data inputs one byte at a time and pops each byte once send_done confirms it.
- Decouples bursty producers from the 10417-cycle-per-bit serial line.

Parameters:
- DEPTH_LOG2, 4, FIFO depth = 2^DEPTH_LOG2 entries.
- TIMEOUT_CYCLES, 150000, watchdog limit in clk cycles; used only with UART_TXQ_TIMEOUT_EN. Fits a 20-bit counter and is more than 12 bit times.

Ports:
- clk  in  1  system clock; single clock domain, shared with the uart.
- rst  in  1  synchronous, active-high reset.
- wr_en  in  1  write strobe; one byte per cycle.
- wr_data  in  8  byte to enqueue.
- full  out  1  FIFO full; writes are ignored while high.
- empty  out  1  FIFO empty.
- count  out  DEPTH_LOG2+1  number of stored bytes.
- overflow  out  1  one-cycle pulse when wr_en arrives while full.
- send  out  1  request to the uart transmitter.
- send_data  out  8  byte presented to the uart; stable while send=1.
- send_done  in  1  uart completion flag; level signal, high from the stop-bit state until the transmitter returns to idle.
- busy  out  1  high whenever FSM is not IDLE or FIFO is not empty.
- drop  out  1  one-cycle pulse when a byte is discarded on timeout; constant 0 without the macro.

Behaviour:
- Reset (sync, rst=1 at posedge clk) sets:
  - rd_ptr=wr_ptr=0, count=0, empty=1, full=0, overflow=0.
  - send=0, send_data=8'h00, busy=0, drop=0, FSM=IDLE, send_done_q=0.
- Reset mid-transfer abandons the queued bytes and deasserts send the next cycle. The uart's own reset is independent.
- FIFO:
  - Circular buffer, pointers DEPTH_LOG2 bits wide, wrapping modulo depth.
  - full = (count==2^DEPTH_LOG2); empty = (count==0).
  - Write occurs when wr_en && !full. Write when full: data discarded, overflow pulses.
  - Write and pop in the same cycle: both happen, count unchanged.
  - Write while full with a same-cycle pop: write rejected, because full is evaluated before the pop.
- send_done is registered once (send_done_q); the FSM uses only send_done_q.
- FSM, 2-bit:
  - IDLE: if !empty, go to LOAD.
  - LOAD: send_data <= mem[rd_ptr]; go to REQ.
  - REQ: send=1. When send_done_q==1: send<=0, pop (rd_ptr+1, count-1), go to DRAIN.
  - DRAIN: send=0; wait for send_done_q==0, then go to IDLE. This blocks re-triggering while the uart is still in its stop state.
- send is dropped the cycle after send_done_q rises. The transmitter therefore sees send=0 on its return to idle, so there are no duplicate frames.
- Latency: wr_en into an empty FIFO at cycle 0 gives count=1 at cycle 1, LOAD at cycle 2, and send=1 with valid send_data at cycle 3.
- Byte order is strictly FIFO. send_data does not change while in REQ or DRAIN.
- count is exact at every cycle. overflow never asserts when !full.

Optional Feature:
- Macro: UART_TXQ_TIMEOUT_EN.
- Defined:
  - A 20-bit watchdog counts cycles spent in REQ, clearing on entry.
  - If it reaches TIMEOUT_CYCLES without send_done_q: send<=0, the byte is popped, drop pulses for 1 cycle, FSM goes to DRAIN.
  - If send_done_q rises on the same cycle as the timeout, normal completion wins and drop stays 0.
- Undefined: no counter is present, REQ waits indefinitely, and drop is tied to 0.

Test Plan:
- Reset then idle 100 cycles -> empty=1, count=0, send=0, send_data=8'h00, busy=0.
- Write 8'hA5 at cycle 0 with a uart model raising send_done 100 cycles after send and lowering it 50 later -> send=1 at cycle 3 with send_data=8'hA5; send=0 one cycle after send_done_q; count returns to 0; busy falls after send_done low.
- Burst 16 writes 8'h00..8'h0F back-to-back with DEPTH_LOG2=4 and the uart stalled (send_done=0) -> full=1 after the 16th. A 17th write 8'hFF gives an overflow pulse, count=16, and 8'hFF never appears. The bytes are then transmitted in order 00..0F.
- Write and completion pop in the same cycle with count=5 -> count stays 5 and wr_ptr/rd_ptr both advance. Also cover pointer wrap past index 15 with 40 total bytes, all in order.
- Hold send_done=1 across two bytes (slow deassert) -> second send not asserted until send_done_q==0, exactly one request per byte.
- With UART_TXQ_TIMEOUT_EN, TIMEOUT_CYCLES=1000, send_done tied 0 -> send falls after 1000 cycles in REQ, drop pulses once, count decrements. Next byte is requested after send_done stays low. Without the macro: send stays high and drop=0.

Source files
------------

// File: rtl/uart_tx_queue.sv
// Byte FIFO and send sequencer feeding the uart transmitter, one frame at a time.
// Optional REQ watchdog that discards a stuck byte: define UART_TXQ_TIMEOUT_EN.
module uart_tx_queue #(
    parameter int unsigned DEPTH_LOG2     = 4,
    parameter int unsigned TIMEOUT_CYCLES = 150000
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  wr_en,
    input  logic [7:0]            wr_data,
    output logic                  full,
    output logic                  empty,
    output logic [DEPTH_LOG2:0]   count,
    output logic                  overflow,
    output logic                  send,
    output logic [7:0]            send_data,
    input  logic                  send_done,
    output logic                  busy,
    output logic                  drop
);

    localparam int unsigned DEPTH = 1 << DEPTH_LOG2;
    localparam int unsigned CW    = DEPTH_LOG2 + 1;

    typedef enum logic [1:0] {StIdle, StLoad, StReq, StDrain} state_e;

    logic [7:0]            mem_q [DEPTH];
    logic [DEPTH_LOG2-1:0] wr_ptr_q;
    logic [DEPTH_LOG2-1:0] rd_ptr_q;
    logic [CW-1:0]         count_q;
    logic                  overflow_q;
    logic                  send_q;
    logic [7:0]            send_data_q;
    logic                  drop_q;
    logic                  send_done_q;
    state_e                state_q;

    logic do_write;
    logic do_pop;
    logic req_done;
    logic req_timeout;

    assign full     = (count_q == CW'(DEPTH));
    assign empty    = (count_q == '0);
    // Full is taken from the registered count, so a same-cycle pop cannot make room.
    assign do_write = wr_en && !full;
    assign req_done = (state_q == StReq) && send_done_q;
    assign do_pop   = req_done || req_timeout;

`ifdef UART_TXQ_TIMEOUT_EN
    logic [19:0] wd_q;

    // Normal completion takes priority over an expiring watchdog.
    assign req_timeout = (state_q == StReq) && !send_done_q &&
                         (wd_q == 20'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge clk) begin
        if (rst) begin
            wd_q <= '0;
        end else if (state_q == StLoad) begin
            wd_q <= '0;
        end else if (state_q == StReq) begin
            wd_q <= wd_q + 20'd1;
        end
    end
`else
    assign req_timeout = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (do_write) begin
            mem_q[wr_ptr_q] <= wr_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            overflow_q <= 1'b0;
        end else begin
            overflow_q <= wr_en && full;
            if (do_write) begin
                wr_ptr_q <= wr_ptr_q + DEPTH_LOG2'(1);
            end
            if (do_pop) begin
                rd_ptr_q <= rd_ptr_q + DEPTH_LOG2'(1);
            end
            if (do_write && !do_pop) begin
                count_q <= count_q + CW'(1);
            end else if (!do_write && do_pop) begin
                count_q <= count_q - CW'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= StIdle;
            send_q      <= 1'b0;
            send_data_q <= 8'h00;
            drop_q      <= 1'b0;
            send_done_q <= 1'b0;
        end else begin
            send_done_q <= send_done;
            drop_q      <= req_timeout;
            case (state_q)
                StIdle: begin
                    if (!empty) begin
                        state_q <= StLoad;
                    end
                end
                StLoad: begin
                    send_data_q <= mem_q[rd_ptr_q];
                    send_q      <= 1'b1;
                    state_q     <= StReq;
                end
                StReq: begin
                    if (do_pop) begin
                        send_q  <= 1'b0;
                        state_q <= StDrain;
                    end
                end
                StDrain: begin
                    // Hold off until the uart has left its stop state.
                    if (!send_done_q) begin
                        state_q <= StIdle;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    assign count     = count_q;
    assign overflow  = overflow_q;
    assign send      = send_q;
    assign send_data = send_data_q;
    assign drop      = drop_q;
    assign busy      = (state_q != StIdle) || !empty;

endmodule

// File: tb/tb_uart_tx_queue.sv
// Randomized bench for uart_tx_queue: queue-based byte model plus a behavioural uart responder.
module tb_uart_tx_queue;

    localparam int DEPTH_LOG2 = 4;
    localparam int DEPTH      = 16;
    localparam int TMO        = 1000;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       wr_en = 1'b0;
    logic [7:0] wr_data = 8'h00;
    logic       send_done = 1'b0;
    logic       full, empty, overflow, send, busy, drop;
    logic [4:0] count;
    logic [7:0] send_data;

    uart_tx_queue #(
        .DEPTH_LOG2     (DEPTH_LOG2),
        .TIMEOUT_CYCLES (TMO)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .wr_en     (wr_en),
        .wr_data   (wr_data),
        .full      (full),
        .empty     (empty),
        .count     (count),
        .overflow  (overflow),
        .send      (send),
        .send_data (send_data),
        .send_done (send_done),
        .busy      (busy),
        .drop      (drop)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    endtask

    // Reference model: bytes held by the queue, front is the next to transmit.
    logic [7:0] q[$];
    bit         sdq_m, ov_m, drop_m;
    bit         frame_active, popped;
    logic [7:0] frame_byte;
    int         req_cycles;
    // Uart responder: 0 idle, 1 shifting, 2 stop state with send_done high.
    int         u_st, u_cnt;
    bit         stall;
    int         dly_lo = 2, dly_hi = 40, hold_lo = 1, hold_hi = 30;
    int         cyc, wr_cyc, quiet, drops_seen;
    bit         lat_arm;

    task automatic step(input bit we, input logic [7:0] wd);
        bit req_m, pop_m, tmo_m, full_m;
        check_eq("count", count, q.size());
        check_eq("full", full, q.size() == DEPTH);
        check_eq("empty", empty, q.size() == 0);
        check_eq("overflow", overflow, ov_m);
        check_eq("drop", drop, drop_m);
        if (drop) drops_seen++;
        if (frame_active) begin
            if (popped) check_eq("send_after_pop", send, 0);
            else        check_eq("send_in_req", send, 1);
            check_eq("send_data_stable", send_data, frame_byte);
        end
        if (q.size() != 0 || (frame_active && !popped)) check_eq("busy_active", busy, 1);
        quiet = (q.size() == 0 && u_st == 0 && !sdq_m) ? quiet + 1 : 0;
        if (quiet >= 2) check_eq("busy_idle", busy, 0);

        case (u_st)
            0: if (send) begin
                if (q.size() == 0) begin
                    check_eq("spurious_send", send, 0);
                end else begin
                    check_eq("frame_data", send_data, q[0]);
                    if (lat_arm) begin
                        check_eq("latency", cyc - wr_cyc, 3);
                        lat_arm = 0;
                    end
                    frame_active = 1;
                    popped       = 0;
                    frame_byte   = q[0];
                    req_cycles   = 0;
                    u_st         = 1;
                    u_cnt        = $urandom_range(dly_hi, dly_lo);
                end
            end
            1: begin
                if (popped) begin
                    u_st = 0;
                    frame_active = 0;
                end else if (!stall) begin
                    if (u_cnt == 0) begin
                        send_done = 1'b1;
                        u_st      = 2;
                        u_cnt     = $urandom_range(hold_hi, hold_lo);
                    end else begin
                        u_cnt--;
                    end
                end
            end
            default: begin
                if (u_cnt == 0) begin
                    send_done    = 1'b0;
                    u_st         = 0;
                    frame_active = 0;
                end else begin
                    u_cnt--;
                end
            end
        endcase

        wr_en   = we;
        wr_data = wd;

        full_m = (q.size() == DEPTH);
        req_m  = frame_active && !popped;
        pop_m  = req_m && sdq_m;
        tmo_m  = 0;
`ifdef UART_TXQ_TIMEOUT_EN
        tmo_m  = req_m && !sdq_m && (req_cycles == TMO - 1);
`endif
        if (req_m) req_cycles++;
        ov_m   = we && full_m;
        drop_m = tmo_m;
        if (pop_m || tmo_m) begin
            void'(q.pop_front());
            popped = 1;
        end
        if (we && !full_m) q.push_back(wd);
        sdq_m = send_done;

        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic drain(input int limit);
        int n = 0;
        while (!(q.size() == 0 && u_st == 0 && quiet >= 3) && n < limit) begin
            step(1'b0, 8'h00);
            n++;
        end
        check_eq("drain_in_time", n < limit, 1);
    endtask

    initial begin
        repeat (3) @(posedge clk);
        #1;
        check_eq("rst_count", count, 0);
        check_eq("rst_empty", empty, 1);
        check_eq("rst_full", full, 0);
        check_eq("rst_send", send, 0);
        check_eq("rst_send_data", send_data, 8'h00);
        check_eq("rst_busy", busy, 0);
        check_eq("rst_drop", drop, 0);
        check_eq("rst_overflow", overflow, 0);
        rst = 1'b0;

        repeat (100) step(1'b0, 8'h00);
        check_eq("idle_empty", empty, 1);
        check_eq("idle_send", send, 0);
        check_eq("idle_send_data", send_data, 8'h00);
        check_eq("idle_busy", busy, 0);

        // Single byte, slow uart, with latency check.
        dly_lo = 100; dly_hi = 100; hold_lo = 50; hold_hi = 50;
        wr_cyc  = cyc;
        lat_arm = 1;
        step(1'b1, 8'hA5);
        drain(1000);
        check_eq("latency_seen", lat_arm, 0);

        // Burst into a stalled uart, then overflow.
        dly_lo = 5; dly_hi = 30; hold_lo = 1; hold_hi = 10;
        stall = 1;
        for (int i = 0; i < 16; i++) step(1'b1, 8'(i));
        check_eq("full_after_16", full, 1);
        step(1'b1, 8'hFF);
        check_eq("overflow_pulse", overflow, 1);
        check_eq("count_after_ovf", count, 16);
        repeat (5) step(1'b0, 8'h00);
        stall = 0;
        drain(5000);

        // Random traffic with varying producer rate and uart timing.
        dly_lo = 2; dly_hi = 40; hold_lo = 1; hold_hi = 30;
        for (int s = 0; s < 15; s++) begin
            int rate = $urandom_range(70, 0);
            repeat (200) step(bit'($urandom_range(99, 0) < rate), 8'($urandom));
        end
        drain(20000);

        // Slow send_done deassert across consecutive bytes.
        dly_lo = 3; dly_hi = 5; hold_lo = 40; hold_hi = 60;
        for (int i = 0; i < 3; i++) step(1'b1, 8'($urandom));
        drain(2000);

        // Uart never completes.
        dly_lo = 2; dly_hi = 10; hold_lo = 1; hold_hi = 5;
        stall = 1;
        drops_seen = 0;
        step(1'b1, 8'h3C);
        step(1'b1, 8'hC3);
        repeat (2200) step(1'b0, 8'h00);
`ifdef UART_TXQ_TIMEOUT_EN
        check_eq("drop_count", drops_seen, 2);
        check_eq("tmo_count", count, 0);
`else
        check_eq("stall_send_held", send, 1);
        check_eq("stall_drop_count", drops_seen, 0);
        check_eq("stall_count", count, 2);
`endif
        stall = 0;
        drain(2000);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
